// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared width constant and count type for the counter family
package counter_pkg;

   localparam int COUNTER_DEFAULT_WIDTH = 8;

   typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter_8b.sv
// rtl/counter_8b.sv - free-running modulo-2^WIDTH up-counter with synchronous reset
module counter_8b
   import counter_pkg::*;
#(
   parameter int WIDTH = COUNTER_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: plain unsigned increment, the carry out of the top bit is dropped
   always_comb begin
      count_d = count_q + WIDTH'(1);
   end

   // Count register: reset takes priority over the increment on the same edge.
   // No power-up value, so out stays unknown until the first reset edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign out = count_q;

`ifdef ASSERT_ON
   a1_reset_clears : assert property (@(posedge clk) reset |=> (out == '0));

   a2_increments : assert property (@(posedge clk)
      (!reset && !$isunknown(out)) |=> (out == WIDTH'($past(out) + WIDTH'(1))));
`endif

endmodule : counter_8b

// File: tb/tb_counter_8b.sv
// tb/tb_counter_8b.sv - directed timeline plus randomized reset traffic against an edge-count model
module tb_counter_8b;

   logic       clk;
   logic       reset;
   logic [7:0] out8;
   logic [3:0] out4;

   int vecs;
   int errs;

   // model: number of non-reset rising edges since the last reset edge
   int n;
   bit known;

   counter_8b #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .out   (out8)
   );

   counter_8b #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .out   (out4)
   );

   // 10-unit period, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic at(input longint t);
      #(t - $time);
   endtask

   // Reference: the count is simply the number of clean edges since reset, mod 2^W
   always @(posedge clk) begin
      if (reset === 1'b1) begin
         known = 1'b1;
         n     = 0;
      end else begin
         n = n + 1;
      end
   end

   // Continuous check half a period after every rising edge
   always @(negedge clk) begin
      if (known) begin
         check("run8", 32'(out8), 32'(n % 256));
         check("run4", 32'(out4), 32'(n % 16));
      end
   end

   initial begin
      vecs  = 0;
      errs  = 0;
      n     = 0;
      known = 1'b0;
      reset = 1'b0;

      at(17);   reset = 1'b1;
      at(26);   check("rst_edge25", 32'(out8), 32'd0);
      at(28);   reset = 1'b0;
      at(36);   check("first_edge35", 32'(out8), 32'd1);
      at(41);   reset = 1'b1;
      at(44);   reset = 1'b0;
      at(56);   check("glitch_edge55", 32'(out8), 32'd3);
      at(57);   reset = 1'b1;
      at(66);   check("rerst_edge65", 32'(out8), 32'd0);
      at(68);   reset = 1'b0;
      at(76);   check("rerst_edge75", 32'(out8), 32'd1);
      at(1066); check("edge1065", 32'(out8), 32'd100);
      check("edge1065_w4", 32'(out4), 32'd4);
      at(2616); check("wrap_255", 32'(out8), 32'd255);
      check("wrap_w4_15", 32'(out4), 32'd15);
      at(2626); check("wrap_0", 32'(out8), 32'd0);
      check("wrap_w4_0", 32'(out4), 32'd0);
      at(2636); check("wrap_1", 32'(out8), 32'd1);

      // randomized reset traffic, including pulses that never see a rising edge
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b1;
            #2;
            reset = 1'b0;
         end
         reset = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      #1;
      reset = 1'b0;
      repeat (300) @(negedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule : tb_counter_8b
